// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_scheduler
//  Brief    : Four-channel microsecond tick scheduler with round-robin expiry
//             offer; optional overrun counters via TICK_SCHEDULER_OVERRUN_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int PERIOD_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                usecond_pulse,
    input  logic                pause,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_chan,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_en,
    output logic                fire_valid,
    output logic [1:0]          fire_chan,
    input  logic                fire_ready
`ifdef TICK_SCHEDULER_OVERRUN_EN
    ,
    output logic [31:0]         ovr_count
`endif
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    localparam logic [PERIOD_W-1:0] c_one = PERIOD_W'(1);

    state_t              r_state;
    logic [1:0]          r_last_grant;
    logic                w_tick;
    logic [PERIOD_W-1:0] w_cfg_period;
    logic [3:0]          w_pending;
    logic [3:0]          w_expire;
    logic [3:0]          w_accept;
    logic [1:0]          w_pick;
    logic                w_found;

    assign w_tick       = usecond_pulse & ~pause;
    assign w_cfg_period = (cfg_period == '0) ? c_one : cfg_period;

    // Round-robin search begins one past the most recently granted channel.
    always_comb begin
        w_pick  = r_last_grant + 2'd1;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && w_pending[r_last_grant + 2'(k)]) begin
                w_pick  = r_last_grant + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic                r_en;
        logic [PERIOD_W-1:0] r_period;
        logic [PERIOD_W-1:0] r_count;
        logic                r_pending;
        logic                w_cfg_hit;

        assign w_cfg_hit   = cfg_we && (cfg_chan == 2'(i));
        assign w_expire[i] = w_tick && r_en && (r_count == c_one) && !w_cfg_hit;
        assign w_accept[i] = (r_state == S_OFFER) && fire_ready && (fire_chan == 2'(i));
        assign w_pending[i] = r_pending;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_en      <= 1'b0;
                r_period  <= '0;
                r_count   <= '0;
                r_pending <= 1'b0;
            end else if (w_cfg_hit) begin
                r_en      <= cfg_en;
                r_period  <= w_cfg_period;
                r_count   <= w_cfg_period;
                r_pending <= 1'b0;
            end else if (w_expire[i]) begin
                // A fresh expiry outranks a simultaneous acceptance.
                r_count   <= r_period;
                r_pending <= 1'b1;
            end else begin
                if (w_tick && r_en && (r_count > c_one)) begin
                    r_count <= r_count - c_one;
                end
                if (w_accept[i]) begin
                    r_pending <= 1'b0;
                end
            end
        end

`ifdef TICK_SCHEDULER_OVERRUN_EN
        logic [7:0] r_ovr;

        always_ff @(posedge clk) begin
            if (rst || w_cfg_hit) begin
                r_ovr <= 8'd0;
            end else if (w_expire[i] && r_pending && !w_accept[i] && (r_ovr != 8'hFF)) begin
                r_ovr <= r_ovr + 8'd1;
            end
        end

        assign ovr_count[8*i +: 8] = r_ovr;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            fire_valid   <= 1'b0;
            fire_chan    <= 2'd0;
            r_last_grant <= 2'd3;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_pending) begin
                        r_state    <= S_OFFER;
                        fire_valid <= 1'b1;
                        fire_chan  <= w_pick;
                    end
                end
                S_OFFER: begin
                    if (fire_ready) begin
                        r_state      <= S_IDLE;
                        fire_valid   <= 1'b0;
                        r_last_grant <= fire_chan;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    fire_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_scheduler
//  Brief    : Self-checking bench for tick_scheduler against a behavioural
//             per-channel model; directed scenarios then random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    logic       clk;
    logic       rst;
    logic       usecond_pulse;
    logic       pause;
    logic       cfg_we;
    logic [1:0] cfg_chan;
    logic [9:0] cfg_period;
    logic       cfg_en;
    logic       fire_valid;
    logic [1:0] fire_chan;
    logic       fire_ready;
`ifdef TICK_SCHEDULER_OVERRUN_EN
    logic [31:0] ovr_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state, expressed directly in the terms of the channel rules.
    int m_en[4];
    int m_period[4];
    int m_cnt[4];
    int m_pend[4];
    int m_ovr[4];
    int m_valid;
    int m_chan;
    int m_last;
    int acc_q[$];
    int cnt_valid;

    tick_scheduler #(.PERIOD_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .usecond_pulse (usecond_pulse),
        .pause         (pause),
        .cfg_we        (cfg_we),
        .cfg_chan      (cfg_chan),
        .cfg_period    (cfg_period),
        .cfg_en        (cfg_en),
        .fire_valid    (fire_valid),
        .fire_chan     (fire_chan),
        .fire_ready    (fire_ready)
`ifdef TICK_SCHEDULER_OVERRUN_EN
        ,
        .ovr_count     (ovr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int acc;
        int tick;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_en[c] = 0; m_period[c] = 0; m_cnt[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
            end
            m_valid = 0; m_chan = 0; m_last = 3;
            return;
        end
        tick = (usecond_pulse && !pause) ? 1 : 0;
        acc  = (m_valid != 0 && fire_ready) ? m_chan : -1;
        if (m_valid == 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_pend[(m_last + k) % 4] != 0) begin
                    m_valid = 1;
                    m_chan  = (m_last + k) % 4;
                    break;
                end
            end
        end else if (fire_ready) begin
            m_valid = 0;
            m_last  = m_chan;
        end
        for (int c = 0; c < 4; c++) begin
            if (cfg_we && int'(cfg_chan) == c) begin
                m_en[c]     = int'(cfg_en);
                m_period[c] = (cfg_period == 0) ? 1 : int'(cfg_period);
                m_cnt[c]    = m_period[c];
                m_pend[c]   = 0;
                m_ovr[c]    = 0;
            end else if (tick != 0 && m_en[c] != 0 && m_cnt[c] == 1) begin
                m_cnt[c] = m_period[c];
                if (m_pend[c] != 0 && acc != c && m_ovr[c] < 255) m_ovr[c]++;
                m_pend[c] = 1;
            end else begin
                if (tick != 0 && m_en[c] != 0 && m_cnt[c] > 1) m_cnt[c]--;
                if (acc == c) m_pend[c] = 0;
            end
        end
    endtask

    task automatic step();
        logic [31:0] e_ovr;
        if (fire_valid === 1'b1 && fire_ready) acc_q.push_back(int'(fire_chan));
        model_edge();
        @(posedge clk);
        #1;
        if (fire_valid === 1'b1) cnt_valid++;
        check("fire_valid", 32'(fire_valid), 32'(m_valid));
        check("fire_chan", 32'(fire_chan), 32'(m_chan));
        e_ovr = '0;
        for (int c = 0; c < 4; c++) e_ovr[8*c +: 8] = 8'(m_ovr[c]);
`ifdef TICK_SCHEDULER_OVERRUN_EN
        check("ovr_count", ovr_count, e_ovr);
`endif
    endtask

    task automatic cfg(input int ch, input int per, input int en);
        cfg_we = 1'b1; cfg_chan = 2'(ch); cfg_period = 10'(per); cfg_en = 1'(en);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic ticks(input int n);
        usecond_pulse = 1'b1;
        repeat (n) step();
        usecond_pulse = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_a[4];
        int exp_b[4];
        exp_a = '{0, 1, 2, 3};
        exp_b = '{2, 3, 0, 1};
        rst = 1'b1; usecond_pulse = 1'b0; pause = 1'b0; cfg_we = 1'b0;
        cfg_chan = 2'd0; cfg_period = 10'd0; cfg_en = 1'b0; fire_ready = 1'b1;
        cnt_valid = 0;

        // Reset state
        do_reset();
        check("rst_valid", 32'(fire_valid), 32'd0);
        check("rst_chan", 32'(fire_chan), 32'd0);

        // Periodic expiry on ch0 every third tick
        cfg(0, 3, 1);
        cnt_valid = 0;
        ticks(12);
        check("p3_valid_count", 32'(cnt_valid), 32'd3);

        // All four channels expire together: two round-robin rounds
        do_reset();
        for (int c = 0; c < 4; c++) cfg(c, 2, 1);
        acc_q.delete();
        ticks(2);
        repeat (10) step();
        check("rr1_len", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) check("rr1_order", 32'(acc_q[i]), 32'(exp_a[i]));
        cfg(1, 1, 1);
        ticks(1);
        repeat (2) step();
        for (int c = 0; c < 4; c++) cfg(c, 2, 1);
        acc_q.delete();
        ticks(2);
        repeat (10) step();
        check("rr2_len", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) check("rr2_order", 32'(acc_q[i]), 32'(exp_b[i]));

        // Stalled consumer: offer holds, later expiries are overruns
        do_reset();
        fire_ready = 1'b0;
        cfg(1, 2, 1);
        ticks(12);
        check("stall_valid", 32'(fire_valid), 32'd1);
        check("stall_chan", 32'(fire_chan), 32'd1);
`ifdef TICK_SCHEDULER_OVERRUN_EN
        check("stall_ovr1", 32'(ovr_count[15:8]), 32'd5);
`endif
        fire_ready = 1'b1;
        step();

        // Pause freezes the countdown
        do_reset();
        cfg(0, 4, 1);
        ticks(1);
        pause = 1'b1;
        cnt_valid = 0;
        ticks(10);
        check("pause_no_event", 32'(cnt_valid), 32'd0);
        pause = 1'b0;
        ticks(3);
        check("pause_latency", 32'(fire_valid), 32'd0);
        step();
        check("pause_resume", 32'(fire_valid), 32'd1);
        step();

        // Cfg write coinciding with expiry, then reset during an offer
        do_reset();
        cfg(2, 3, 1);
        ticks(2);
        usecond_pulse = 1'b1;
        cfg(2, 5, 1);
        usecond_pulse = 1'b0;
        repeat (2) step();
        check("cfg_wins", 32'(fire_valid), 32'd0);
        fire_ready = 1'b0;
        ticks(5);
        step();
        check("offer_up", 32'(fire_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_drop", 32'(fire_valid), 32'd0);
        fire_ready = 1'b1;

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            usecond_pulse = ($urandom_range(0, 1) == 1);
            pause         = ($urandom_range(0, 4) == 0);
            cfg_we        = ($urandom_range(0, 9) == 0);
            cfg_chan      = 2'($urandom_range(0, 3));
            cfg_period    = 10'($urandom_range(0, 6));
            cfg_en        = ($urandom_range(0, 4) != 0);
            fire_ready    = ($urandom_range(0, 4) < 3);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
